test_completion_monitor: RTL and testbench
==========================================

Name: test_completion_monitor

Overview:
- Passive, synthesizable monitor placed beside the soc data-memory write port.
- Snoops stores to decide when a program has finished, instead of running for a fixed cycle count.
- Captures a parametrised window of signature words and detects the TOHOST pass/fail write.
- Enforces a cycle timeout, giving benches and FPGA builds a single done/pass/fail verdict.

Parameters:
- ADDR_WIDTH, 32, snooped address width.
- DATA_WIDTH, 32, snooped data width.
- TOHOST_ADDR, 32'h0000_1FFC, byte address whose store ends the test.
- SIG_BASE_ADDR, 32'h0000_1F00, byte address of signature word 0.
- NUM_SIG, 4, number of signature words captured (1..16).
- TIMEOUT_CYCLES, 1000, RUN cycles before timeout (>=1).
- CNT_WIDTH, 32, width of cycle counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- start  in  1  pulse; begins monitoring.
- wr_en  in  1  snooped store valid.
- wr_addr  in  ADDR_WIDTH  snooped store byte address.
- wr_data  in  DATA_WIDTH  snooped store data.
- done  out  1  verdict reached (pass, fail or timeout).
- pass  out  1  TOHOST written with 1.
- timeout  out  1  TIMEOUT_CYCLES elapsed without TOHOST store.
- fail_code  out  DATA_WIDTH-1  tohost_value>>1 on failure.
- cycle_count  out  CNT_WIDTH  RUN cycles elapsed.
- sig_data  out  NUM_SIG*DATA_WIDTH  captured words; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- sig_valid  out  NUM_SIG  bit k set once word k has been written.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- Reset: all outputs 0, FSM in IDLE, signature registers 0. Reset mid-RUN aborts and clears everything in the next cycle.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. Stores are ignored in IDLE.
  - RUN -> DONE on an accepted TOHOST store, or when cycle_count reaches TIMEOUT_CYCLES-1 with no store.
  - DONE is sticky until rst. start in RUN or DONE is ignored.
- cycle_count: 0 on entering RUN; +1 each RUN cycle; frozen in DONE; saturates at all-ones.
- TOHOST store: accepted when wr_en and wr_addr==TOHOST_ADDR in RUN.
  - Data 1: pass=1, fail_code=0.
  - Data 0: ignored; stay in RUN.
  - Other data: pass=0, fail_code=wr_data[DATA_WIDTH-1:1].
  - done and pass/fail_code become visible the cycle after the store. Latency is 1.
- Signature capture: in RUN, wr_en with wr_addr in [SIG_BASE_ADDR, SIG_BASE_ADDR+4*NUM_SIG) and wr_addr[1:0]==0.
  - Index k=(wr_addr-SIG_BASE_ADDR)>>2. sig_data word k <= wr_data; sig_valid[k] <= 1.
  - Rewrites overwrite. Misaligned or out-of-window addresses are ignored.
  - Signature stores in DONE are ignored; values stay frozen.
- Simultaneous events:
  - TOHOST store in the same cycle the timeout condition is met: the store wins (timeout=0).
  - A store whose address matches both TOHOST and the signature window: treated as TOHOST only.
- timeout=1 implies done=1, pass=0, fail_code=0.

Optional Feature:
- Macro: TEST_MONITOR_WRCNT_EN.
- Defined:
  - Adds output port wr_count (CNT_WIDTH): number of wr_en cycles seen in RUN, any address.
  - Counts the final TOHOST store, frozen in DONE, saturating, cleared by rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- start, then store 0x1 to 0x1FFC at RUN cycle 20 -> next cycle done=1, pass=1, fail_code=0, cycle_count=21 then frozen.
- start, store 0x7 to 0x1FFC -> done=1, pass=0, fail_code=3, timeout=0.
- start, stores 0xA/0xB/0xC to 0x1F00/0x1F04/0x1F0C, store to 0x1F02 and 0x1F10 -> sig_valid=4'b1011, words 0xA, 0xB, 0, 0xC; then store 1 to TOHOST, later store to 0x1F04 -> word 1 stays 0xB.
- TIMEOUT_CYCLES=50, start, no TOHOST -> done=1, timeout=1 at RUN cycle 50, cycle_count=49; a second run with TOHOST=1 on cycle 49 -> pass=1, timeout=0.
- Store 0 to TOHOST -> still RUN, done=0. Assert rst mid-RUN -> next cycle all outputs 0, IDLE; stores before a new start have no effect.
- With TEST_MONITOR_WRCNT_EN: 5 arbitrary stores plus TOHOST=1 -> wr_count=6, unchanged after further stores.

Source files
------------

// File: rtl/test_completion_monitor.sv
// Passive store-snooping monitor that produces a done/pass/fail/timeout verdict and captures a signature window.
// Optional define TEST_MONITOR_WRCNT_EN adds the wr_count port counting stores seen while running.
module test_completion_sig_word #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] WORD_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  valid
);
    // An exact match on the word address also rejects misaligned and out-of-window stores.
    logic hit;
    assign hit = capture && (wr_addr == WORD_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            word  <= '0;
            valid <= 1'b0;
        end else if (hit) begin
            word  <= wr_data;
            valid <= 1'b1;
        end
    end
endmodule

module test_completion_monitor #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1FFC,
    parameter logic [31:0] SIG_BASE_ADDR  = 32'h0000_1F00,
    parameter int          NUM_SIG        = 4,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          CNT_WIDTH      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          wr_en,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [DATA_WIDTH-2:0]         fail_code,
    output logic [CNT_WIDTH-1:0]          cycle_count,
    output logic [NUM_SIG*DATA_WIDTH-1:0] sig_data,
    output logic [NUM_SIG-1:0]            sig_valid
`ifdef TEST_MONITOR_WRCNT_EN
    ,
    output logic [CNT_WIDTH-1:0]          wr_count
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] TOHOST       = TOHOST_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] SIG_BASE     = SIG_BASE_ADDR[ADDR_WIDTH-1:0];
    localparam logic [CNT_WIDTH-1:0]  TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] PASS_VALUE   = DATA_WIDTH'(1);

    state_t state, state_nxt;
    logic   running;
    logic   tohost_hit;
    logic   tohost_accept;
    logic   tmo_hit;
    logic   cnt_inc;
    logic   sig_capture;

    assign running       = (state == RUN);
    assign tohost_hit    = running && wr_en && (wr_addr == TOHOST);
    // A zero write to TOHOST is not a verdict; the program keeps running.
    assign tohost_accept = tohost_hit && (wr_data != '0);
    assign tmo_hit       = running && (cycle_count == TIMEOUT_LAST);
    // The final timeout cycle is not counted, but a verdict store on that cycle is.
    assign cnt_inc       = running && (tohost_accept || !tmo_hit) && !(&cycle_count);
    // TOHOST takes priority if it ever falls inside the signature window.
    assign sig_capture   = running && wr_en && (wr_addr != TOHOST);
    assign done          = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (tohost_accept || tmo_hit) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cycle_count <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_code   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)
                cycle_count <= '0;
            else if (cnt_inc)
                cycle_count <= cycle_count + CNT_WIDTH'(1);
            if (tohost_accept) begin
                pass      <= (wr_data == PASS_VALUE);
                fail_code <= wr_data[DATA_WIDTH-1:1];
            end else if (tmo_hit) begin
                timeout <= 1'b1;
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_SIG; k++) begin : g_sig
            test_completion_sig_word #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .DATA_WIDTH (DATA_WIDTH),
                .WORD_ADDR  (SIG_BASE + ADDR_WIDTH'(4 * k))
            ) u_word (
                .clk     (clk),
                .rst     (rst),
                .capture (sig_capture),
                .wr_addr (wr_addr),
                .wr_data (wr_data),
                .word    (sig_data[k*DATA_WIDTH +: DATA_WIDTH]),
                .valid   (sig_valid[k])
            );
        end
    endgenerate

`ifdef TEST_MONITOR_WRCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            wr_count <= '0;
        else if (running && wr_en && !(&wr_count))
            wr_count <= wr_count + CNT_WIDTH'(1);
    end
`endif
endmodule

// File: tb/tb_test_completion_monitor.sv
// Directed bench for test_completion_monitor: verdicts, signature capture, timeout and reset abort.
module tb_test_completion_monitor;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          wr_en = 1'b0;
    logic [31:0]   wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          done, pass, timeout;
    logic [30:0]   fail_code;
    logic [31:0]   cycle_count;
    logic [NS*32-1:0] sig_data;
    logic [NS-1:0] sig_valid;
`ifdef TEST_MONITOR_WRCNT_EN
    logic [31:0]   wr_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    test_completion_monitor #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TOHOST_ADDR    (32'h0000_1FFC),
        .SIG_BASE_ADDR  (32'h0000_1F00),
        .NUM_SIG        (NS),
        .TIMEOUT_CYCLES (50),
        .CNT_WIDTH      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .fail_code   (fail_code),
        .cycle_count (cycle_count),
        .sig_data    (sig_data),
        .sig_valid   (sig_valid)
`ifdef TEST_MONITOR_WRCNT_EN
        ,
        .wr_count    (wr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".done"},    128'(done),        0);
        chk({tag, ".pass"},    128'(pass),        0);
        chk({tag, ".timeout"}, 128'(timeout),     0);
        chk({tag, ".fail"},    128'(fail_code),   0);
        chk({tag, ".count"},   128'(cycle_count), 0);
        chk({tag, ".sigv"},    128'(sig_valid),   0);
        chk({tag, ".sigd"},    128'(sig_data),    0);
`ifdef TEST_MONITOR_WRCNT_EN
        chk({tag, ".wrcnt"},   128'(wr_count),    0);
`endif
    endtask

    initial begin
        // Pass verdict after store at RUN cycle 20
        do_reset();
        chk_cleared("reset");
        start_run();
        chk("t1.count0", 128'(cycle_count), 0);
        chk("t1.done0",  128'(done), 0);
        step(20);
        chk("t1.count20", 128'(cycle_count), 20);
        store(32'h1FFC, 32'h1);
        chk("t1.done",    128'(done), 1);
        chk("t1.pass",    128'(pass), 1);
        chk("t1.fail",    128'(fail_code), 0);
        chk("t1.timeout", 128'(timeout), 0);
        chk("t1.count",   128'(cycle_count), 21);
        start = 1'b1;
        step(3);
        start = 1'b0;
        chk("t1.frozen", 128'(cycle_count), 21);
        chk("t1.sticky", 128'(done), 1);

        // Fail verdict
        do_reset();
        start_run();
        step(2);
        store(32'h1FFC, 32'h7);
        chk("t2.done",    128'(done), 1);
        chk("t2.pass",    128'(pass), 0);
        chk("t2.fail",    128'(fail_code), 3);
        chk("t2.timeout", 128'(timeout), 0);
        chk("t2.count",   128'(cycle_count), 3);

        // Signature capture with misaligned and out-of-window stores
        do_reset();
        start_run();
        store(32'h1F00, 32'hA);
        store(32'h1F04, 32'hB);
        store(32'h1F0C, 32'hC);
        store(32'h1F02, 32'hD);
        store(32'h1F10, 32'hE);
        chk("t3.sigv", 128'(sig_valid), 128'b1011);
        chk("t3.sigd", 128'(sig_data), {32'hC, 32'h0, 32'hB, 32'hA});
        chk("t3.run",  128'(done), 0);
        store(32'h1FFC, 32'h1);
        chk("t3.done", 128'(done), 1);
        store(32'h1F04, 32'h55);
        store(32'h1F08, 32'h66);
        chk("t3.frozen_d", 128'(sig_data), {32'hC, 32'h0, 32'hB, 32'hA});
        chk("t3.frozen_v", 128'(sig_valid), 128'b1011);

        // Timeout at RUN cycle 50, then TOHOST winning on the last cycle
        do_reset();
        start_run();
        step(49);
        chk("t4.pre_done", 128'(done), 0);
        chk("t4.pre_cnt",  128'(cycle_count), 49);
        step();
        chk("t4.done",    128'(done), 1);
        chk("t4.timeout", 128'(timeout), 1);
        chk("t4.pass",    128'(pass), 0);
        chk("t4.fail",    128'(fail_code), 0);
        chk("t4.count",   128'(cycle_count), 49);
        step(2);
        chk("t4.frozen",  128'(cycle_count), 49);
        do_reset();
        start_run();
        step(49);
        store(32'h1FFC, 32'h1);
        chk("t4b.done",    128'(done), 1);
        chk("t4b.pass",    128'(pass), 1);
        chk("t4b.timeout", 128'(timeout), 0);
        chk("t4b.count",   128'(cycle_count), 50);

        // Zero TOHOST keeps running; reset mid-RUN aborts; IDLE ignores stores
        do_reset();
        start_run();
        step(3);
        store(32'h1FFC, 32'h0);
        chk("t5.done0", 128'(done), 0);
        chk("t5.count", 128'(cycle_count), 4);
        store(32'h1F00, 32'h77);
        chk("t5.sigv",  128'(sig_valid), 1);
        do_reset();
        chk_cleared("t5.abort");
        store(32'h1FFC, 32'h1);
        store(32'h1F04, 32'h99);
        chk_cleared("t5.idle");
        start_run();
        step(2);
        chk("t5.rerun_cnt",  128'(cycle_count), 2);
        chk("t5.rerun_done", 128'(done), 0);

`ifdef TEST_MONITOR_WRCNT_EN
        // Store counter includes the final TOHOST store and freezes in DONE
        do_reset();
        start_run();
        store(32'h0100, 32'h1);
        store(32'h1F00, 32'h2);
        store(32'h1FF8, 32'h3);
        store(32'h0000, 32'h4);
        store(32'h1F04, 32'h5);
        chk("t6.cnt5", 128'(wr_count), 5);
        store(32'h1FFC, 32'h1);
        chk("t6.cnt6", 128'(wr_count), 6);
        store(32'h0200, 32'h6);
        store(32'h1FFC, 32'h1);
        chk("t6.frozen", 128'(wr_count), 6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
